// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcode map, FSM states and the
// bit positions of the status flags inside the registered flag vector.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_DBZ   = 3;
  localparam int FLAG_W     = 4;

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// The quotient output is the value the quotient register takes on this edge,
// so it is the finished quotient in the cycle where done is high.
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  import alu_pkg::*;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Shift the next dividend bit into the partial remainder and subtract the divisor when it fits.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    done   = 1'b0;
    trial  = {rem_q, quo_q[WIDTH-1]};
    diff   = trial[WIDTH-1:0] - dvs_q;
    fits   = (trial >= {1'b0, dvs_q});
    if (busy_q) begin
      rem_d = fits ? diff : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], fits};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        done   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end
  end

  // Divider state registers; reset abandons any division in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_d;

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides. Every opcode
// completes in one cycle except a divide by a non-zero divisor, which is
// handed to the iterative divider while the FSM sits in DIV.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             DivByZero
);
  import alu_pkg::*;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    alu_out_q, alu_out_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;

  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic [WIDTH-1:0]    op_res;
  logic                op_carry;
  logic                op_ovf;
  logic                op_dbz;

  logic                accept;
  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [WIDTH-1:0]    div_quotient;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (A),
    .divisor  (B),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  assign in_ready = (state_q == ST_IDLE) && !div_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath: result plus carry/overflow/div-by-zero for the current opcode.
  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    diff     = {1'b0, A} - {1'b0, B};
    op_res   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    op_dbz   = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        op_res   = sum[WIDTH-1:0];
        op_carry = sum[WIDTH];
        op_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        op_res   = diff[WIDTH-1:0];
        op_carry = diff[WIDTH];
        op_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL:  op_res = A * B;
      OP_DIV: begin
        op_res = '1;
        op_dbz = 1'b1;
      end
      OP_SHL: begin
        op_res   = {A[WIDTH-2:0], 1'b0};
        op_carry = A[WIDTH-1];
      end
      OP_SHR: begin
        op_res   = {1'b0, A[WIDTH-1:1]};
        op_carry = A[0];
      end
      OP_ROL: begin
        op_res   = {A[WIDTH-2:0], A[WIDTH-1]};
        op_carry = A[WIDTH-1];
      end
      OP_ROR: begin
        op_res   = {A[0], A[WIDTH-1:1]};
        op_carry = A[0];
      end
      OP_AND:  op_res = A & B;
      OP_OR:   op_res = A | B;
      OP_XOR:  op_res = A ^ B;
      OP_NOR:  op_res = ~(A | B);
      OP_NAND: op_res = ~(A & B);
      OP_XNOR: op_res = ~(A ^ B);
      OP_GT:   op_res = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   op_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: op_res = '0;
    endcase
  end

  // FSM and output register control: load results, hold under backpressure, track the divide.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    div_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((ALU_Sel == OP_DIV) && (B != '0)) begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end else begin
            alu_out_d           = op_res;
            flags_d             = '0;
            flags_d[FLAG_CARRY] = op_carry;
            flags_d[FLAG_OVF]   = op_ovf;
            flags_d[FLAG_DBZ]   = op_dbz;
            flags_d[FLAG_ZERO]  = (op_res == '0);
            out_valid_d         = 1'b1;
          end
        end
      end
      ST_DIV: begin
        if (div_done) begin
          alu_out_d          = div_quotient;
          flags_d            = '0;
          flags_d[FLAG_ZERO] = (div_quotient == '0);
          out_valid_d        = 1'b1;
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALU_Out   = alu_out_q;
  assign CarryOut  = flags_q[FLAG_CARRY];
  assign Overflow  = flags_q[FLAG_OVF];
  assign Zero      = flags_q[FLAG_ZERO];
  assign DivByZero = flags_q[FLAG_DBZ];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios on an 8-bit instance, then a
// randomized run on a 16-bit instance scored against an arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv8, ir8, ov8, or8, c8, o8, z8, d8;
  logic [7:0] a8, b8, out8;
  logic [3:0] sel8;

  logic        iv16, ir16, ov16, or16, c16, o16, z16, d16;
  logic [15:0] a16, b16, out16;
  logic [3:0]  sel16;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .ALU_Sel(sel8), .out_valid(ov8), .out_ready(or8), .ALU_Out(out8),
    .CarryOut(c8), .Overflow(o8), .Zero(z8), .DivByZero(d8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .ALU_Sel(sel16), .out_valid(ov16), .out_ready(or16), .ALU_Out(out16),
    .CarryOut(c16), .Overflow(o16), .Zero(z16), .DivByZero(d16)
  );

  // Compare one observed value against its expectation and count the outcome.
  task automatic checkOutput(input string tag, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Result and flags packed as {result, carry, overflow, zero, divbyzero}.
  function automatic longint unsigned pk(input longint unsigned res, input bit c,
                                         input bit o, input bit z, input bit d);
    return (res << 4) | (longint'(c) << 3) | (longint'(o) << 2) | (longint'(z) << 1) | longint'(d);
  endfunction

  function automatic longint unsigned act8();
    return pk(longint'(out8), c8, o8, z8, d8);
  endfunction

  function automatic longint unsigned act16();
    return pk(longint'(out16), c16, o16, z16, d16);
  endfunction

  // Arithmetic reference: what a w-bit ALU should return for a, b and opcode sel.
  function automatic longint unsigned refModel(input int w, input longint unsigned a,
                                               input longint unsigned b, input int sel);
    longint unsigned mask = (64'd1 << w) - 1;
    longint          half = longint'(64'd1 << (w - 1));
    longint          sa, sb, s;
    longint unsigned res = 0;
    bit c = 0, o = 0, d = 0;
    sa = (a >= longint'(half)) ? longint'(a) - longint'(mask + 1) : longint'(a);
    sb = (b >= longint'(half)) ? longint'(b) - longint'(mask + 1) : longint'(b);
    case (sel)
      0: begin res = (a + b) & mask; c = ((a + b) >> w) != 0; s = sa + sb; o = (s > half - 1) || (s < -half); end
      1: begin res = (a - b) & mask; c = a < b; s = sa - sb; o = (s > half - 1) || (s < -half); end
      2: res = (a * b) & mask;
      3: if (b == 0) begin res = mask; d = 1; end else res = a / b;
      4: begin res = (a << 1) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      5: begin res = a >> 1; c = (a & 1) != 0; end
      6: begin res = ((a << 1) | (a >> (w - 1))) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      7: begin res = (a >> 1) | ((a & 1) << (w - 1)); c = (a & 1) != 0; end
      8: res = a & b;
      9: res = a | b;
      10: res = a ^ b;
      11: res = ~(a | b) & mask;
      12: res = ~(a & b) & mask;
      13: res = ~(a ^ b) & mask;
      14: res = (a > b) ? 1 : 0;
      default: res = (a == b) ? 1 : 0;
    endcase
    return pk(res, c, o, res == 0, d);
  endfunction

  // Present one operation to the 8-bit instance and return at the negedge after it is accepted.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    int n = 0;
    a8 = a; b8 = b; sel8 = sel; iv8 = 1'b1;
    #1;
    while (!ir8 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!ir8) checkOutput("accept_timeout", 0, 1);
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  initial begin
    bit busy_ok, hold_ok, stale, acc;
    int issued, consumed, cyc;
    longint unsigned expq[$];
    longint unsigned expv;

    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; sel8 = 0; or8 = 1;
    iv16 = 0; a16 = 0; b16 = 0; sel16 = 0; or16 = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", ir8, 1);
    checkOutput("reset_out_valid", ov8, 0);
    checkOutput("reset_outputs", act8(), 0);

    applyStimulus(8'd200, 8'd100, OP_ADD);
    checkOutput("add_carry", act8(), pk(44, 1, 0, 0, 0));
    checkOutput("add_valid", ov8, 1);
    applyStimulus(8'd5, 8'd7, OP_SUB);
    checkOutput("sub_borrow", act8(), pk(254, 1, 0, 0, 0));
    applyStimulus(8'd100, 8'd100, OP_ADD);
    checkOutput("add_overflow", act8(), pk(200, 0, 1, 0, 0));
    applyStimulus(8'd20, 8'd13, OP_MUL);
    checkOutput("mul_low", act8(), pk(4, 0, 0, 0, 0));
    applyStimulus(8'h81, 8'h00, OP_SHL);
    checkOutput("shl", act8(), pk(8'h02, 1, 0, 0, 0));
    applyStimulus(8'h81, 8'h00, OP_SHR);
    checkOutput("shr", act8(), pk(8'h40, 1, 0, 0, 0));
    applyStimulus(8'h81, 8'h00, OP_ROL);
    checkOutput("rol", act8(), pk(8'h03, 1, 0, 0, 0));
    applyStimulus(8'h81, 8'h00, OP_ROR);
    checkOutput("ror", act8(), pk(8'hC0, 1, 0, 0, 0));
    applyStimulus(8'd3, 8'd3, OP_GT);
    checkOutput("gt_equal", act8(), pk(0, 0, 0, 1, 0));
    applyStimulus(8'd3, 8'd3, OP_EQ);
    checkOutput("eq_equal", act8(), pk(1, 0, 0, 0, 0));

    a8 = 8'd200; b8 = 8'd7; sel8 = OP_DIV; iv8 = 1'b1;
    #1;
    checkOutput("div_accept_ready", ir8, 1);
    @(negedge clk);
    iv8 = 1'b0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (ir8 || ov8) busy_ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("div_busy_window", busy_ok, 1);
    checkOutput("div_valid", ov8, 1);
    checkOutput("div_result", act8(), pk(28, 0, 0, 0, 0));

    applyStimulus(8'd9, 8'd0, OP_DIV);
    checkOutput("div_by_zero", act8(), pk(255, 0, 0, 0, 1));

    applyStimulus(8'hF0, 8'hF0, OP_XOR);
    or8 = 1'b0;
    a8 = 8'd1; b8 = 8'd1; sel8 = OP_ADD; iv8 = 1'b1;
    #1;
    checkOutput("bp_xor", act8(), pk(0, 0, 0, 1, 0));
    hold_ok = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (act8() != pk(0, 0, 0, 1, 0) || !ov8 || ir8) hold_ok = 1'b0;
    end
    checkOutput("bp_hold", hold_ok, 1);
    or8 = 1'b1;
    #1;
    checkOutput("bp_ready", ir8, 1);
    @(negedge clk);
    iv8 = 1'b0;
    checkOutput("bp_new_result", act8(), pk(2, 0, 0, 0, 0));
    checkOutput("bp_new_valid", ov8, 1);

    a8 = 8'd200; b8 = 8'd7; sel8 = OP_DIV; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_div_in_ready", ir8, 1);
    checkOutput("rst_div_out_valid", ov8, 0);
    checkOutput("rst_div_outputs", act8(), 0);
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) stale = 1'b1;
    end
    checkOutput("rst_no_stale", stale, 0);

    issued = 0; consumed = 0; cyc = 0; acc = 1'b0;
    while (consumed < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (acc) iv16 = 1'b0;
      acc = 1'b0;
      or16 = ($urandom_range(0, 3) != 0);
      if (!iv16 && issued < NRAND && $urandom_range(0, 3) != 0) begin
        int r;
        sel16 = 4'($urandom_range(0, 15));
        a16 = 16'($urandom);
        r = $urandom_range(0, 7);
        if (r == 0) b16 = 16'd0;
        else if (r == 1) b16 = a16;
        else b16 = 16'($urandom);
        iv16 = 1'b1;
      end
      #1;
      if (ov16 && or16) begin
        if (expq.size() == 0) begin
          checkOutput("rand_spurious", 1, 0);
        end else begin
          expv = expq.pop_front();
          checkOutput("rand_result", act16(), expv);
        end
        consumed++;
      end
      if (iv16 && ir16) begin
        expq.push_back(refModel(16, longint'(a16), longint'(b16), int'(sel16)));
        issued++;
        acc = 1'b1;
      end
    end
    checkOutput("rand_consumed", consumed, NRAND);
    checkOutput("rand_leftover", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
